// File: rtl/nla_sched_pkg.sv
// Shared definitions for the nonlinear-approximation job scheduler:
// FSM state encoding, default widths and the wait-counter sizing helper.
package nla_sched_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t WAIT  = 2'd2;
   localparam state_t RESP  = 2'd3;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_FUNC_W = 2;

   // Counter only has to reach TIMEOUT-1.
   function automatic int cnt_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/nla_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward (mod N).
// Ports: req (requests), ptr (last grant), gnt (one-hot), gnt_idx (index).
module nla_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] idx;

   // Walk from lowest to highest priority; the last hit wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/nla_job_scheduler.sv
// Round-robin job scheduler sharing one nonlinear-approximation engine.
// Ports: req_* (job requests), cfg_* (degree table), eng_* (engine), rsp_* (results).
module nla_job_scheduler
   import nla_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FUNC_W     = DEF_FUNC_W,
   parameter int ADDR_LINES = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_x,
   input  logic [NUM_REQ*FUNC_W-1:0] req_func,
   input  logic                      cfg_we,
   input  logic [FUNC_W-1:0]         cfg_func,
   input  logic [ADDR_LINES-1:0]     cfg_degree,
   output logic                      eng_start,
   output logic                      eng_abort,
   output logic [DATA_W-1:0]         eng_x,
   output logic [FUNC_W-1:0]         eng_func,
   output logic [ADDR_LINES-1:0]     eng_degree,
   input  logic                      eng_done,
   input  logic [DATA_W-1:0]         eng_result,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err
);

   localparam int IW       = $clog2(NUM_REQ);
   localparam int NUM_FUNC = 1 << FUNC_W;
   localparam int CW       = cnt_width(TIMEOUT);

   state_t                state_q, state_d;
   logic [IW-1:0]         rr_q, rr_d;
   logic [IW-1:0]         id_q, id_d;
   logic [DATA_W-1:0]     x_q, x_d;
   logic [FUNC_W-1:0]     func_q, func_d;
   logic [ADDR_LINES-1:0] deg_q, deg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  err_q, err_d;
   logic [ADDR_LINES-1:0] tab_q [NUM_FUNC];
   logic [ADDR_LINES-1:0] tab_d [NUM_FUNC];

   logic [NUM_REQ-1:0]    gnt;
   logic [IW-1:0]         gnt_idx;
   logic [FUNC_W-1:0]     func_sel;
   logic                  to_hit;

   nla_rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign func_sel = req_func[gnt_idx*FUNC_W +: FUNC_W];
   assign to_hit   = (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= IW'(NUM_REQ - 1);
         id_q    <= '0;
         x_q     <= '0;
         func_q  <= '0;
         deg_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         tab_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         x_q     <= x_d;
         func_q  <= func_d;
         deg_q   <= deg_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
         tab_q   <= tab_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      x_d     = x_q;
      func_d  = func_q;
      deg_d   = deg_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      tab_d   = tab_q;
      if (cfg_we) tab_d[cfg_func] = cfg_degree;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d = ISSUE;
               rr_d    = gnt_idx;
               id_d    = gnt_idx;
               x_d     = req_x[gnt_idx*DATA_W +: DATA_W];
               func_d  = func_sel;
               // Table read is pre-write: same-cycle cfg goes to later jobs.
               deg_d   = tab_q[func_sel];
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Done takes priority over a coincident timeout.
            if (eng_done) begin
               data_d  = eng_result;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (to_hit) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready[id_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE) ? gnt : '0;
      eng_start = (state_q == ISSUE);
      eng_abort = (state_q == WAIT) && !eng_done && to_hit;
      rsp_valid = '0;
      if (state_q == RESP) rsp_valid[id_q] = 1'b1;
   end

   assign eng_x      = x_q;
   assign eng_func   = func_q;
   assign eng_degree = deg_q;
   assign rsp_data   = data_q;
   assign rsp_err    = err_q;

endmodule

// File: tb/tb_nla_job_scheduler.sv
// Self-checking bench for nla_job_scheduler: directed scenarios plus
// randomized traffic compared every cycle against a job-age reference model.
module tb_nla_job_scheduler;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int FW = 2;
   localparam int AW = 4;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_x = '0;
   logic [N*FW-1:0] req_func = '0;
   logic            cfg_we = 1'b0;
   logic [FW-1:0]   cfg_func = '0;
   logic [AW-1:0]   cfg_degree = '0;
   logic            eng_start;
   logic            eng_abort;
   logic [DW-1:0]   eng_x;
   logic [FW-1:0]   eng_func;
   logic [AW-1:0]   eng_degree;
   logic            eng_done = 1'b0;
   logic [DW-1:0]   eng_result = '0;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '0;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;

   int tests = 0;
   int fails = 0;

   nla_job_scheduler #(
      .NUM_REQ    (N),
      .DATA_W     (DW),
      .FUNC_W     (FW),
      .ADDR_LINES (AW),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_func   (req_func),
      .cfg_we     (cfg_we),
      .cfg_func   (cfg_func),
      .cfg_degree (cfg_degree),
      .eng_start  (eng_start),
      .eng_abort  (eng_abort),
      .eng_x      (eng_x),
      .eng_func   (eng_func),
      .eng_degree (eng_degree),
      .eng_done   (eng_done),
      .eng_result (eng_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- engine model ----------------
   int          lat = 12;
   bit          spur = 1'b0;
   bit          fix_res = 1'b0;
   logic [DW-1:0] fixed_res = '0;
   int          cd = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (eng_abort) cd = 0;
         if (eng_start) cd = (lat > 0) ? lat : 0;
         @(posedge clk);
         #1;
         eng_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               eng_done   = 1'b1;
               eng_result = fix_res ? fixed_res : DW'($urandom);
            end
         end else if (spur && $urandom_range(0, 15) == 0) begin
            eng_done   = 1'b1;
            eng_result = DW'($urandom);
         end
      end
   end

   // ---------------- reference model ----------------
   // A job is tracked by its age in cycles since acceptance:
   // age 1 = start cycle, age >= 2 = waiting for done (age-2 cycles so far).
   bit            m_busy = 0;
   bit            m_fin = 0;
   int            m_age = 0;
   int            m_id = 0;
   int            m_rr = N - 1;
   logic [DW-1:0] m_x = '0;
   logic [FW-1:0] m_f = '0;
   logic [AW-1:0] m_deg = '0;
   logic [DW-1:0] m_data = '0;
   bit            m_err = 0;
   logic [AW-1:0] m_tab [1 << FW];

   initial begin
      for (int i = 0; i < (1 << FW); i++) m_tab[i] = '0;
      forever begin
         logic [N-1:0] e_rdy;
         logic [N-1:0] e_rv;
         logic         e_st;
         logic         e_ab;
         int           g;
         @(negedge clk);
         e_rdy = '0;
         e_rv  = '0;
         e_st  = 1'b0;
         e_ab  = 1'b0;
         g     = -1;
         if (!m_busy) begin
            for (int k = 1; k <= N; k++)
               if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g >= 0) e_rdy[g] = 1'b1;
         end else if (m_fin) begin
            e_rv[m_id] = 1'b1;
         end else if (m_age == 1) begin
            e_st = 1'b1;
         end else if (!eng_done && (m_age - 2) == TO - 1) begin
            e_ab = 1'b1;
         end
         chk("model_cycle",
             {req_ready, eng_start, eng_abort, rsp_valid, eng_x, eng_func, eng_degree},
             {e_rdy, e_st, e_ab, e_rv, m_x, m_f, m_deg});
         if (m_busy && m_fin)
            chk("model_rsp", {rsp_data, rsp_err}, {m_data, m_err});
         if (rst) begin
            m_busy = 0;
            m_fin  = 0;
            m_rr   = N - 1;
            m_x    = '0;
            m_f    = '0;
            m_deg  = '0;
            m_data = '0;
            m_err  = 0;
            for (int i = 0; i < (1 << FW); i++) m_tab[i] = '0;
         end else begin
            if (!m_busy) begin
               if (g >= 0) begin
                  m_busy = 1;
                  m_fin  = 0;
                  m_age  = 1;
                  m_id   = g;
                  m_rr   = g;
                  m_x    = req_x[g*DW +: DW];
                  m_f    = req_func[g*FW +: FW];
                  m_deg  = m_tab[m_f];
               end
            end else if (m_fin) begin
               if (rsp_ready[m_id]) m_busy = 0;
            end else if (m_age >= 2) begin
               if (eng_done) begin
                  m_fin  = 1;
                  m_data = eng_result;
                  m_err  = 0;
               end else if (e_ab) begin
                  m_fin  = 1;
                  m_data = '0;
                  m_err  = 1;
               end else begin
                  m_age++;
               end
            end else begin
               m_age++;
            end
            if (cfg_we) m_tab[cfg_func] = cfg_degree;
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      cfg_we    = 1'b0;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] x,
                          input logic [FW-1:0] f);
      req_x[i*DW +: DW]    = x;
      req_func[i*FW +: FW] = f;
   endtask

   // which: 0 = req_ready, 1 = rsp_valid, 2 = eng_abort
   task automatic wait_sig(input int which, output int n);
      bit hit;
      hit = 1'b0;
      n   = 0;
      while (!hit && n < 100) begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = (req_ready != '0);
            1:       hit = (rsp_valid != '0);
            default: hit = eng_abort;
         endcase
      end
      if (!hit) begin
         tests++;
         fails++;
         $display("FAIL wait_%0d: no event within %0d cycles", which, n);
      end
   endtask

   initial begin
      int n;
      logic [DW-1:0] held;
      rsp_ready = '1;
      cyc(3);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outs",
          {req_ready, eng_start, eng_abort, rsp_valid, eng_x, eng_func,
           eng_degree, rsp_data, rsp_err}, 64'd0);

      // single job
      cyc(1);
      cfg_we = 1'b1; cfg_func = 2'd1; cfg_degree = 4'd5;
      cyc(1);
      cfg_we = 1'b0;
      fix_res = 1'b1; fixed_res = 16'hBEEF; lat = 12;
      set_req(2, 16'h1234, 2'd1);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t1_grant", req_ready, 4'b0100);
      cyc(1);
      req_valid = '0;
      @(negedge clk);
      chk("t1_start", {eng_start, eng_x, eng_func, eng_degree},
          {1'b1, 16'h1234, 2'd1, 4'd5});
      wait_sig(1, n);
      chk("t1_latency", n, 13);
      chk("t1_rsp", {rsp_valid, rsp_data, rsp_err}, {4'b0100, 16'hBEEF, 1'b0});
      fix_res = 1'b0;

      // round robin with all requesters active
      cyc(1);
      do_reset();
      lat = 2;
      for (int i = 0; i < N; i++) set_req(i, DW'($urandom), FW'($urandom));
      req_valid = '1;
      for (int j = 0; j < 5; j++) begin
         wait_sig(0, n);
         chk($sformatf("t2_grant%0d", j), req_ready, 4'b0001 << (j % 4));
      end
      cyc(1);
      req_valid = '0;
      wait_sig(1, n);

      // timeout: engine never answers
      lat = 0;
      cyc(1);
      req_valid = 4'b0010;
      wait_sig(0, n);
      cyc(1);
      req_valid = '0;
      wait_sig(2, n);
      chk("t3_abort_cycle", n, TO + 1);
      chk("t3_no_rsp_yet", rsp_valid, 4'b0000);
      @(negedge clk);
      chk("t3_rsp", {rsp_valid, rsp_data, rsp_err}, {4'b0010, 16'h0000, 1'b1});

      // backpressure
      lat = 3;
      cyc(1);
      rsp_ready = '0;
      set_req(0, 16'h5A5A, 2'd2);
      req_valid = 4'b0001;
      wait_sig(0, n);
      cyc(1);
      req_valid = '0;
      wait_sig(1, n);
      held = rsp_data;
      cyc(1);
      req_valid = 4'b1110;
      rsp_ready = 4'b1110;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("t4_hold", {rsp_valid, rsp_data, req_ready}, {4'b0001, held, 4'b0000});
      end
      cyc(1);
      rsp_ready = 4'b0001;
      @(negedge clk);
      chk("t4_handshake", req_ready, 4'b0000);
      cyc(1);
      rsp_ready = '1;
      @(negedge clk);
      chk("t4_next_grant", req_ready, 4'b0010);
      cyc(1);
      req_valid = '0;
      wait_sig(1, n);

      // degree-table write racing an accept
      cyc(1);
      do_reset();
      cfg_we = 1'b1; cfg_func = 2'd0; cfg_degree = 4'd3;
      set_req(3, 16'h0F0F, 2'd0);
      req_valid = 4'b1000;
      @(negedge clk);
      chk("t5_grant", req_ready, 4'b1000);
      cyc(1);
      cfg_we = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("t5_old_deg", {eng_start, eng_degree}, {1'b1, 4'd0});
      wait_sig(1, n);
      cyc(1);
      req_valid = 4'b1000;
      wait_sig(0, n);
      cyc(1);
      req_valid = '0;
      @(negedge clk);
      chk("t5_new_deg", {eng_start, eng_degree}, {1'b1, 4'd3});
      wait_sig(1, n);

      // reset while waiting; late done must be ignored
      lat = 10;
      cyc(1);
      set_req(2, 16'h7777, 2'd3);
      req_valid = 4'b0100;
      wait_sig(0, n);
      cyc(1);
      req_valid = '0;
      cyc(4);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_outs",
          {req_ready, eng_start, eng_abort, rsp_valid, eng_x, eng_func,
           eng_degree, rsp_data, rsp_err}, 64'd0);
      cyc(10);
      req_valid = '1;
      @(negedge clk);
      chk("t6_grant0", req_ready, 4'b0001);
      cyc(1);
      req_valid = '0;
      wait_sig(1, n);

      // randomized traffic
      spur = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         cyc(1);
         rst        = ($urandom_range(0, 299) == 0);
         lat        = $urandom_range(0, 22);
         req_valid  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         rsp_ready  = N'($urandom);
         req_x      = {$urandom, $urandom};
         req_func   = N*FW'($urandom);
         cfg_we     = ($urandom_range(0, 3) == 0);
         cfg_func   = FW'($urandom);
         cfg_degree = AW'($urandom);
      end
      cyc(1);
      spur      = 1'b0;
      rst       = 1'b0;
      cfg_we    = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      cyc(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
